exp_series_unit: RTL

Parametrised fixed-point exponential engine for the pricing datapath. It computes y = e^(+x) or e^(-x) per request using argument halving: r = x/2^SHIFT, then an NTERMS-term Horner Taylor series, then SHIFT repeated squarings. It uses valid/ready handshakes on both sides and saturates with an overflow flag. It serves as the drop-in exponential for discount-factor and d1/d2 stages that need e^(+x), a selectable width, or backpressure.

---
 rtl/exp_series_pkg.sv | 25 ++
 rtl/exp_series_unit_mul.sv | 36 +++
 rtl/exp_series_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/exp_series_pkg.sv
// Shared types and elaboration-time constants for the fixed-point exponential engine.
package exp_series_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERIES = 2'd1,
    SQUARE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Taylor order counter (NTERMS <= 15) and squaring counter (SHIFT <= 7)
  localparam int unsigned KW = 4;
  localparam int unsigned JW = 3;

  function automatic longint fx_one(input int unsigned frac);
    return longint'(1) << frac;
  endfunction

  // round(2^frac / k), half rounded up; k == 0 is never used and yields 0
  function automatic longint inv_coef(input int unsigned k, input int unsigned frac);
    if (k == 0) return longint'(0);
    return ((longint'(1) << frac) + longint'(k / 2)) / longint'(k);
  endfunction

endpackage

// File: rtl/exp_series_unit_mul.sv
// Signed fixed-point multiply with round-half-up and saturation to the WIDTH range.
module fxp_mul_sat #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p,
  output logic                    sat
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (FRAC - 1);
  localparam logic signed [PW-1:0] PMAX = (PW'(1) <<< (WIDTH - 1)) - PW'(1);
  localparam logic signed [PW-1:0] PMIN = -(PW'(1) <<< (WIDTH - 1));

  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] rnd_c;
  logic signed [PW-1:0] shr_c;

  always_comb begin
    prod_c = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    rnd_c  = prod_c + RND;
    shr_c  = rnd_c >>> FRAC;
    sat    = 1'b0;
    p      = shr_c[WIDTH-1:0];
    if (shr_c > PMAX) begin
      p   = PMAX[WIDTH-1:0];
      sat = 1'b1;
    end else if (shr_c < PMIN) begin
      p   = PMIN[WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/exp_series_unit.sv
// Iterative e^(+/-x): argument halving, Horner Taylor series, then repeated squaring.
module exp_series_unit
  import exp_series_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned NTERMS = 8,
  parameter int unsigned SHIFT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(fx_one(FRAC));
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] r_q, r_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]           k_q, k_d;
  logic [JW-1:0]           j_q, j_d;
  logic                    sticky_q, sticky_d;
  logic                    ovf_q, ovf_d;
  logic                    out_valid_q, out_valid_d;

  // 1/k coefficients, fixed at elaboration
  logic signed [WIDTH-1:0] inv_tbl [16];
  for (genvar g = 0; g < 16; g++) begin : g_inv
    assign inv_tbl[g] = WIDTH'(inv_coef(g, FRAC));
  end

  logic signed [WIDTH-1:0] m0_a, m0_p, m1_p;
  logic                    m0_sat, m1_sat;

  // First multiplier is r*acc in SERIES and acc*acc in SQUARE
  assign m0_a = (state_q == SQUARE) ? acc_q : r_q;

  fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul0 (
    .a(m0_a), .b(acc_q), .p(m0_p), .sat(m0_sat)
  );

  fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul1 (
    .a(m0_p), .b(inv_tbl[k_q]), .p(m1_p), .sat(m1_sat)
  );

  logic signed [WIDTH:0]   sum_c;
  logic                    add_sat_c;
  logic signed [WIDTH-1:0] series_c;
  logic                    neg_sat_c;
  logic signed [WIDTH-1:0] xn_c;

  always_comb begin
    sum_c     = {ONE[WIDTH-1], ONE} + {m1_p[WIDTH-1], m1_p};
    add_sat_c = sum_c[WIDTH] != sum_c[WIDTH-1];
    series_c  = sum_c[WIDTH-1:0];
    if (add_sat_c) series_c = sum_c[WIDTH] ? MINV : MAXV;
    // Negating the most-negative value has no representation; pin it to max
    neg_sat_c = neg && ($signed(x) == MINV);
    xn_c      = neg ? -$signed(x) : $signed(x);
    if (neg_sat_c) xn_c = MAXV;
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    acc_d       = acc_q;
    k_d         = k_q;
    j_d         = j_q;
    sticky_d    = sticky_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d      = xn_c >>> SHIFT;
          acc_d    = ONE;
          k_d      = KW'(NTERMS);
          j_d      = '0;
          sticky_d = neg_sat_c;
          state_d  = SERIES;
        end
      end
      SERIES: begin
        acc_d    = series_c;
        sticky_d = sticky_q | m0_sat | m1_sat | add_sat_c;
        k_d      = k_q - KW'(1);
        if (k_q == KW'(1)) begin
          if (SHIFT == 0) begin
            y_d         = series_c[WIDTH-1] ? '0 : series_c;
            ovf_d       = sticky_d;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            j_d     = JW'(1);
            state_d = SQUARE;
          end
        end
      end
      SQUARE: begin
        acc_d    = m0_p;
        sticky_d = sticky_q | m0_sat;
        j_d      = j_q + JW'(1);
        if (j_q == JW'(SHIFT)) begin
          y_d         = m0_p[WIDTH-1] ? '0 : m0_p;
          ovf_d       = sticky_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      k_q         <= '0;
      j_q         <= '0;
      sticky_q    <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      k_q         <= k_d;
      j_q         <= j_d;
      sticky_q    <= sticky_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule
